// File: rtl/rr_mux_arbiter_pkg.sv
// Shared defaults and the round-robin search used by the picker (and usable by models).
// Optional build macro RR_MUX_ARBITER_PACKET_LOCK_EN is consumed by rr_mux_arbiter only.
package rr_mux_arbiter_pkg;
    localparam int RR_N_IN_DEF   = 4;
    localparam int RR_W_DEF      = 8;
    localparam int RR_MAX_N      = 32;
    localparam int RR_MAX_IDX_W  = 5;

    // First set bit of req[n-1:0] searched from ptr+1 with wrap; returns n when nothing is set.
    function automatic int rr_first_after(input logic [RR_MAX_N-1:0] req, input int ptr, input int n);
        int idx;
        rr_first_after = n;
        for (int k = RR_MAX_N; k >= 1; k--) begin
            if (k <= n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[RR_MAX_IDX_W'(idx)]) rr_first_after = idx;
            end
        end
    endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: combinational, zero latency, one-hot grant of the first request after ptr.
// No backpressure of its own; the caller qualifies the grant.
module rr_priority_picker
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N_IN  = RR_N_IN_DEF,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_IN-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);
    logic [RR_MAX_N-1:0] req_ext;
    int                  sel;

    always_comb begin
        req_ext            = '0;
        req_ext[N_IN-1:0]  = req;
        sel                = rr_first_after(req_ext, int'(ptr), N_IN);
        any_grant          = (sel < N_IN);
        grant_idx          = any_grant ? IDX_W'(sel) : '0;
        grant              = any_grant ? (N_IN'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// N:1 round-robin arbiter with registered data mux; 1-cycle latency, full throughput, stalls hold output.
// Optional RR_MUX_ARBITER_PACKET_LOCK_EN adds in_last/out_last and locks the grant until end of packet.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int  N_IN  = RR_N_IN_DEF,
    parameter int  W     = RR_W_DEF,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN-1:0][W-1:0]   in_data,
    output logic [N_IN-1:0]          in_ready,
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    input  logic [N_IN-1:0]          in_last,
    output logic                     out_last,
`endif
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [IDX_W-1:0]         out_src,
    input  logic                     out_ready
);
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             can_load, xfer, any_grant;
    logic [N_IN-1:0]  req, grant;
    logic [IDX_W-1:0] grant_idx;

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_src_q, lock_src_d;
    logic             out_last_q, out_last_d;

    // While a packet is open only its owner may request, even if it is not valid right now.
    assign req      = lock_q ? (in_valid & (N_IN'(1) << lock_src_q)) : in_valid;
    assign out_last = out_last_q;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        out_last_d = out_last_q;
        if (xfer) begin
            lock_d     = !in_last[grant_idx];
            lock_src_d = grant_idx;
            out_last_d = in_last[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_src_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            out_last_q <= out_last_d;
        end
    end
`else
    assign req = in_valid;
`endif

    assign can_load = !rst && (!out_valid_q || out_ready);
    assign xfer     = any_grant && can_load;
    assign in_ready = can_load ? grant : '0;

    rr_priority_picker #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx];
            out_src_d   = grant_idx;
            ptr_d       = grant_idx;
        end else if (can_load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= IDX_W'(N_IN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rr_mux_arbiter;
    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      in_valid;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [1:0]      out_src;
    logic            out_ready;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    logic [3:0]      in_last;
    logic            out_last;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state: last accepted source and the beat held at the output.
    int         m_ptr;
    bit         m_vld;
    logic [7:0] m_dat;
    int         m_src;

    always #5 clk = ~clk;

    rr_mux_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    function automatic int pick(input logic [3:0] v, input int p);
        int j;
        pick = -1;
        for (int k = 4; k >= 1; k--) begin
            j = (p + k) % 4;
            if (v[j[1:0]]) pick = j;
        end
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        bit can;
        g   = pick(in_valid, m_ptr);
        can = !m_vld || out_ready;
        exp_ready = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_ptr = 3;
        m_vld = 0;
        m_dat = 8'h00;
        m_src = 0;
    endtask

    // Advance one clock and apply the transfer the model predicts for the current inputs.
    task automatic tick();
        int g;
        bit can;
        g   = pick(in_valid, m_ptr);
        can = !m_vld || out_ready;
        if (can && g >= 0) begin
            m_vld = 1;
            m_dat = in_data[g[1:0]];
            m_src = g;
            m_ptr = g;
        end else if (can) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i] = 8'(8'h10 + i);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
        checks++; if (out_data !== 8'h00 || out_src !== 2'd0) begin errors++; $display("FAIL reset_out_regs got %h/%0d exp 00/0", out_data, out_src); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h10) begin
            errors++; $display("FAIL reset_first_beat got v=%b src=%0d dat=%h exp v=1 src=0 dat=10", out_valid, out_src, out_data);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i] = 8'(8'hA0 + i);
        in_valid = 4'b1111;
        #1;
        for (int c = 0; c < 8; c++) begin
            checks++; if (in_ready !== exp_ready() || in_ready !== 4'(1 << (c % 4))) begin
                errors++; $display("FAIL fair_in_ready c=%0d got %b exp %b", c, in_ready, 4'(1 << (c % 4)));
            end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== 8'(8'hA0 + c % 4)) begin
                errors++; $display("FAIL fair_out c=%0d got v=%b src=%0d dat=%h exp v=1 src=%0d dat=%h",
                                   c, out_valid, out_src, out_data, c % 4, 8'(8'hA0 + c % 4));
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i] = 8'(8'h50 + i);
        in_data[1] = 8'h5C;
        in_valid   = 4'b0010;
        tick();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 4'b0000 || in_ready !== exp_ready()) begin
                errors++; $display("FAIL bp_in_ready c=%0d got %b exp 0000", c, in_ready);
            end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 8'h5C) begin
                errors++; $display("FAIL bp_hold c=%0d got v=%b src=%0d dat=%h exp v=1 src=1 dat=5c", c, out_valid, out_src, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant got %b exp 0100", in_ready); end
        tick();
        checks++; if (out_src !== 2'd2 || out_data !== 8'h52) begin
            errors++; $display("FAIL bp_release_beat got src=%0d dat=%h exp src=2 dat=52", out_src, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_sparse_wrap();
        int exp_src[4] = '{0, 3, 0, 3};
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i] = 8'(8'hC0 + i);
        in_valid = 4'b1001;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL wrap_in_ready c=%0d got %b exp %b", c, in_ready, exp_ready()); end
            tick();
            checks++; if (out_src !== 2'(exp_src[c]) || out_valid !== 1'b1) begin
                errors++; $display("FAIL wrap_src c=%0d got src=%0d v=%b exp src=%0d v=1", c, out_src, out_valid, exp_src[c]);
            end
        end
        in_valid = 4'b0100;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready c=%0d got %b exp 0100", c, in_ready); end
            tick();
            checks++; if (out_src !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'hC2) begin
                errors++; $display("FAIL single_beat c=%0d got src=%0d v=%b dat=%h exp src=2 v=1 dat=c2", c, out_src, out_valid, out_data);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_idle_drain();
        do_reset();
        in_data[1] = 8'h3D;
        in_valid   = 4'b0010;
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin errors++; $display("FAIL drain_beat got v=%b src=%0d exp v=1 src=1", out_valid, out_src); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h3D) begin
            errors++; $display("FAIL drain_empty got v=%b dat=%h exp v=0 dat=3d", out_valid, out_data);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_stay_empty got v=%b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i] = 8'(8'h70 + i);
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h70) begin errors++; $display("FAIL areset_setup got v=%b dat=%h exp v=1 dat=70", out_valid, out_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            errors++; $display("FAIL areset_immediate got v=%b dat=%h src=%0d exp v=0 dat=00 src=0", out_valid, out_data, out_src);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL areset_restart got %b exp 0001", in_ready); end
        tick();
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL areset_restart_src got %0d exp 0", out_src); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] acc;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_ready());
            end
            acc = in_valid & in_ready;
            tick();
            checks++; if (out_valid !== m_vld || (m_vld && (out_src !== 2'(m_src) || out_data !== m_dat))) begin
                errors++; $display("FAIL rand_out cyc=%0d got v=%b src=%0d dat=%h exp v=%b src=%0d dat=%h",
                                   cyc, out_valid, out_src, out_data, m_vld, m_src, m_dat);
            end
            in_valid = in_valid & ~acc;
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();
    endtask

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    task automatic test_packet_lock();
        int exp_last[3] = '{0, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i] = 8'(8'hE0 + i);
        in_last  = 4'b1111;
        in_valid = 4'b0010;
        @(posedge clk);
        #1;
        in_valid = 4'b0111;
        in_last  = 4'b1011;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) in_last = 4'b1111;
            in_data[2] = 8'(8'h20 + b);
            #1;
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL lock_in_ready b=%0d got %b exp 0100", b, in_ready); end
            @(posedge clk);
            #1;
            checks++; if (out_src !== 2'd2 || out_last !== 1'(exp_last[b]) || out_data !== 8'(8'h20 + b)) begin
                errors++; $display("FAIL lock_beat b=%0d got src=%0d last=%b dat=%h exp src=2 last=%0d dat=%h",
                                   b, out_src, out_last, out_data, exp_last[b], 8'(8'h20 + b));
            end
        end
        in_valid = 4'b0011;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_resume got %b exp 0001", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_src !== 2'd0 || out_last !== 1'b1) begin errors++; $display("FAIL lock_resume_src got src=%0d last=%b exp src=0 last=1", out_src, out_last); end
        in_valid = 4'b0000;
        do_reset();
    endtask
`endif

    initial begin
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        in_last = 4'b1111;
`endif
        in_data = '0;
        model_reset();
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_idle_drain();
        test_async_reset();
        test_random();
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        test_packet_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
